cbus_arbiter: RTL
=================

Name: cbus_arbiter

Overview:
- Shares the single cache-side memory bus (cbus) between N cache requesters, e.g. ICache port 0 and DCache port 1.
- Grants one requester at a time and holds the grant for a whole burst, up to and including the beat with cresp.last.
- Uses round-robin priority between transactions.
- Sits between the L1 caches and the memory/AXI bridge at the core top level.

Parameters:
- NUM_INPUTS, 2, number of cbus requesters (≥2).
- CHECK_BEATS, 1, when 1, enables beat-count checking against creq.len.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-low.
- ireqs  input  NUM_INPUTS x cbus_req_t  requests from the caches.
- iresps  output  NUM_INPUTS x cbus_resp_t  responses to the caches.
- oreq  output  cbus_req_t  request to the memory side.
- oresp  input  cbus_resp_t  response from the memory side.
- busy  output  1  high while a granted transaction is in flight.
- grant_idx  output  $clog2(NUM_INPUTS)  index of the current/last granted requester.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset==0 at posedge):
  - state←IDLE, rr_ptr←0, grant_idx←0, beat_cnt←0, err←0.
  - oreq.valid=0, all iresps zero, busy=0 from the next cycle.
  - Reset mid-burst abandons the burst; memory side is reset together.
- State IDLE:
  - oreq='0, iresps all '0, busy=0.
  - Pick the first i with ireqs[i].valid, scanning i=rr_ptr, rr_ptr+1, … modulo NUM_INPUTS.
  - If one is found: grant_idx←i, beat_cnt←ireqs[i].len+1 (len encodes beats−1: MLEN1→1, MLEN16→16), state←BUSY.
  - No valid requester: stay IDLE.
  - Arbitration latency is 1 cycle: oreq.valid is never asserted in the cycle the decision is made.
- State BUSY:
  - oreq = ireqs[grant_idx], combinational pass-through.
  - iresps[grant_idx] = oresp; all other iresps = '0 (ready=0, last=0).
  - busy=1.
  - On oresp.ready: beat_cnt←beat_cnt−1.
  - On oresp.ready && oresp.last: state←IDLE, rr_ptr←(grant_idx+1) mod NUM_INPUTS.
- Minimum 1 IDLE cycle between consecutive transactions, even to the same requester.
- Fairness:
  - The requester just served has the lowest priority next round.
  - With NUM_INPUTS=2, neither requester waits more than one full transaction plus 2 cycles.
- Requests from non-granted ports are ignored and never dropped. They are picked up at the next IDLE, provided valid is still held.
- Granted requester deasserts valid while BUSY:
  - Protocol violation; err←1.
  - Grant is held; the arbiter still waits for oresp.last.
- Beat checking (CHECK_BEATS=1), evaluated on oresp.ready in BUSY:
  - err←1 if last=1 while beat_cnt≠1.
  - err←1 if last=0 while beat_cnt==1.
  - beat_cnt is 5 bits wide and never wraps below 0: it saturates at 0 and err is set.
- err is sticky and is cleared only by reset.
- Simultaneous last and a new valid from another port: the transition to IDLE occurs, and the new port is arbitrated in IDLE on the following cycle.

Decomposition:
- common package:
  - reuses cbus_req_t, cbus_resp_t, mlen_t.
  - adds a shared arb_state_t enum {IDLE, BUSY} for reuse by later bus arbiters.
- Sub-module rr_picker:
  - combinational round-robin priority encoder.
  - Inputs: valid vector, rr_ptr. Outputs: found, index.
  - Reused later for the uncached/MMIO port.

Test Plan:
- Only port 1 requests, MLEN16 read; memory returns 16 ready beats, last on beat 16 → oreq.valid rises 1 cycle after ireqs[1].valid; iresps[1] sees 16 ready pulses; iresps[0] stays 0; busy drops after last; err=0.
- Ports 0 and 1 both valid from reset, each MLEN16 → port 0 served first, then port 1; after the next requests, port 0 again; grant_idx sequence 0,1,0.
- Port 0 MLEN1 uncached write (strobe 8'hFF), then port 1 MLEN16 → port 0 gets 1 beat with last; port 1 granted after 1 IDLE cycle; err=0.
- Memory asserts last on beat 15 of an MLEN16 burst → err=1 and stays 1; state returns to IDLE; the next transaction completes normally.
- Reset driven low at beat 8 of a port-1 burst → next cycle oreq.valid=0, busy=0, err=0, grant_idx=0; after release, a port-0 request is granted first.
- Granted port drops valid mid-burst → err=1; grant held until last; no response is ever routed to the other port.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus request/response types and the arbiter state encoding used by
// cbus_arbiter and later bus arbiters.
package cbus_arbiter_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int STRB_W     = DATA_W / 8;
  localparam int BEAT_CNT_W = 5;

  // len encodes beats-1.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    mlen_t             len;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  function automatic logic [BEAT_CNT_W-1:0] mlen_beats(input mlen_t len);
    return BEAT_CNT_W'(len) + BEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set bit of valid,
// scanning upward from rr_ptr and wrapping modulo N.
module cbus_arbiter_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    int j;
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned infers a latch.
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && valid[IDX_W'(j)]) begin
        found = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus between NUM_INPUTS cache requesters;
// a grant is held for a whole burst and a sticky err flags protocol faults.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int CHECK_BEATS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  cbus_req_t                     ireqs [NUM_INPUTS],
  output cbus_resp_t                    iresps[NUM_INPUTS],
  output cbus_req_t                     oreq,
  input  cbus_resp_t                    oresp,
  output logic                          busy,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                          err
);

  localparam int                    IDX_W    = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [BEAT_CNT_W-1:0] ONE_BEAT = BEAT_CNT_W'(1);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;

  logic [NUM_INPUTS-1:0] req_valid;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  cbus_req_t             granted_req;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
  end

  cbus_arbiter_rr_picker #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign granted_req = ireqs[grant_idx_q];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    oreq        = '0;
    busy        = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;

    unique case (state_q)
      IDLE: begin
        // Grant takes effect next cycle, so oreq.valid never rises here.
        if (pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = mlen_beats(ireqs[pick_idx].len);
          state_d     = BUSY;
        end
      end

      BUSY: begin
        oreq                = granted_req;
        iresps[grant_idx_q] = oresp;
        busy                = 1'b1;
        // Requester withdrew mid-burst; the burst still runs to last.
        if (!granted_req.valid) err_d = 1'b1;
        if (oresp.ready) begin
          if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - ONE_BEAT;
          if (CHECK_BEATS != 0 &&
              ((oresp.last != (beat_cnt_q == ONE_BEAT)) || beat_cnt_q == '0))
            err_d = 1'b1;
          if (oresp.last) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state updates use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign err       = err_q;

endmodule
